signet_vec_loader: RTL
======================

# signet_vec_loader

Upstream stimulus stage for the `signet` combinational core. It assembles 39-bit input vectors from an 8-bit valid/ready byte stream and drives them onto the core's `v0..v38` inputs from a register. It captures the core's 8-bit `v39.*` result and returns it on a valid/ready output stream. It also accumulates input switching activity (Hamming distance between consecutive applied vectors) for the power-aware synthesis flow.

## Interface
Parameters:
- `VEC_W`, 39: core input width (`v0`..`v38`).
- `RES_W`, 8: core output width (`v39.0`..`v39.7`).
- `NBYTES`, 5: bytes per vector, equal to ceil(VEC_W/8).
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_data`, in, 8: vector byte.
- `in_valid`, in, 1: byte valid.
- `in_ready`, out, 1: byte accepted when high with `in_valid`.
- `vec_o`, out, VEC_W: registered drive to the core; bit i drives `vi`.
- `res_i`, in, RES_W: core result; bit j is `v39.j`.
- `out_data`, out, RES_W: captured result.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accept.
- `clr_stats`, in, 1: synchronous clear of both counters.
- `toggle_cnt`, out, CNT_W: saturating sum of applied-vector bit toggles.
- `vec_cnt`, out, CNT_W: completed vectors, wrapping.

## Operation
- FSM states:
  - COLLECT: `in_ready`=1. Each accepted byte is written to staging byte `idx`, then `idx`++. Byte 0 maps to `v0..v7`, byte 4 maps to `v32..v38`. Byte 4 bit 7 is ignored. Accepting the byte at `idx`=4 moves the FSM to APPLY.
  - APPLY: `vec_o` <= staging. `toggle_cnt` += popcount(staging ^ old `vec_o`), saturating at 2^CNT_W-1. Next state CAPTURE.
  - CAPTURE: `out_data` <= `res_i`, `out_valid` <= 1. Next state EMIT.
  - EMIT: hold `out_data` and `out_valid` stable until `out_ready`. On handshake: `out_valid` <= 0, `vec_cnt`++ (wraps), `idx` <= 0, next state COLLECT.
- `in_ready` = (state==COLLECT) && !`rst`. It is low in APPLY, CAPTURE and EMIT. There is no byte buffering.
- `vec_o` changes only in APPLY, so the core inputs stay stable while a vector is evaluated and emitted.
- Popcount range is 0..39 (6 bits). It is zero-extended before the add. On saturation the counter holds at all-ones.
- `clr_stats` sets both counters to 0 on the next edge. If it coincides with an APPLY increment or an EMIT increment, the clear wins and that increment is lost. `clr_stats` does not affect the FSM or `vec_o`.
- Reset (any state, including mid-collection or mid-EMIT):
  - state COLLECT, `idx`=0, staging=0.
  - `vec_o`=0, `out_data`=0, `out_valid`=0.
  - `toggle_cnt`=0, `vec_cnt`=0.
  - A partial vector is discarded. A pending result is dropped without handshake.

## Timing
- The last byte is accepted at edge E0. `vec_o` updates at E1. `out_valid` rises at E2.
- The core has one full cycle (E1 to E2) to settle. `res_i` is sampled only at E2.
- The fastest vector period is 5 + 2 + 1 = 8 cycles: 5 byte cycles, APPLY, CAPTURE, and an EMIT with `out_ready` already high.
- With `out_ready` held high in EMIT, the handshake completes in the first EMIT cycle. `in_ready` rises on the following cycle.
- Every output is a register except `in_ready`, which is decoded from state.

## Structure
- Shared package `signet_pkg`:
  - constants `SIGNET_VEC_W`=39, `SIGNET_RES_W`=8, `SIGNET_NBYTES`=5.
  - the FSM state enum {COLLECT, APPLY, CAPTURE, EMIT}.
- One sub-module, `signet_popcount`: a combinational VEC_W-bit population count with a 6-bit result.
- The `signet` core is instantiated by the enclosing test wrapper, not inside this block.

## Test plan
- Reset, then bytes 0xFF, 0x00, 0x00, 0x00, 0x7F: `vec_o`=0x7F000000FF at E1, `toggle_cnt`=15, `out_valid` at E2, `out_data`=`res_i`.
- Back-to-back vector 0x7F000000FF after that: `toggle_cnt` stays 15, `vec_cnt`=2 after the second handshake.
- Byte 4 = 0xFF: `vec_o[38:32]`=0x7F; bit 7 is dropped.
- `out_ready` low for 10 cycles in EMIT: `out_data` stable, `in_ready`=0, `vec_o` unchanged; the handshake releases the FSM to COLLECT.
- `toggle_cnt` preloaded near max by alternating 0 and all-ones vectors (39 toggles each) for 1700 vectors: counter holds at 0xFFFF; `clr_stats` pulse gives 0.
- `rst` asserted after 3 bytes: `in_ready` low during reset, `vec_o`=0, `idx`=0; the next 5 bytes form a fresh vector.

Source files
------------

// File: rtl/signet_pkg.sv
// signet_pkg: shared constants and FSM state encoding
// for the signet stimulus/capture stage.
package signet_pkg;

  localparam int SIGNET_VEC_W  = 39;
  localparam int SIGNET_RES_W  = 8;
  localparam int SIGNET_NBYTES = 5;

  typedef enum logic [1:0] {
    COLLECT,
    APPLY,
    CAPTURE,
    EMIT
  } state_e;

endpackage

// File: rtl/signet_vec_loader_if.sv
// signet_vec_loader_if: byte input stream and result
// output stream, both valid/ready.
interface signet_vec_loader_if #(
  parameter int RES_W = 8
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/signet_popcount.sv
// signet_popcount: combinational population count
// of a VEC_W-bit word, 6-bit result.
module signet_popcount #(
  parameter int VEC_W = 39
) (
  input  logic [VEC_W-1:0] vec_i,
  output logic [5:0]       cnt_o
);

  // Sum of set bits.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < VEC_W; i++) begin
      cnt_o = cnt_o + 6'(vec_i[i]);
    end
  end

endmodule

// File: rtl/signet_vec_loader.sv
// signet_vec_loader: assembles byte-stream vectors for
// the signet core, captures its result, counts toggles.
module signet_vec_loader
  import signet_pkg::*;
#(
  parameter int VEC_W  = SIGNET_VEC_W,
  parameter int RES_W  = SIGNET_RES_W,
  parameter int NBYTES = SIGNET_NBYTES,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  signet_vec_loader_if.slave bus,
  output logic [VEC_W-1:0] vec_o,
  input  logic [RES_W-1:0] res_i,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam int STG_W = NBYTES * 8;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [RES_W-1:0]   odata_q, odata_d;
  logic               ovalid_q, ovalid_d;
  logic [CNT_W-1:0]   tog_q, tog_d;
  logic [CNT_W-1:0]   vcnt_q, vcnt_d;

  logic [5:0]         pc;
  logic [CNT_W:0]     tsum;

  // Bits that would toggle if staging were applied now.
  signet_popcount #(
    .VEC_W (VEC_W)
  ) u_pc (
    .vec_i (stage_q[VEC_W-1:0] ^ vec_q),
    .cnt_o (pc)
  );

  assign tsum = {1'b0, tog_q} + (CNT_W+1)'(pc);

  // Byte acceptance is decoded straight from state.
  assign bus.in_ready  = (state_q == COLLECT) && !rst;
  assign bus.out_data  = odata_q;
  assign bus.out_valid = ovalid_q;
  assign vec_o         = vec_q;
  assign toggle_cnt    = tog_q;
  assign vec_cnt       = vcnt_q;

  // Next-state and datapath updates for the FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    vec_d    = vec_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    tog_d    = tog_q;
    vcnt_d   = vcnt_q;
    unique case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          stage_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          stage_d[STG_W-1:VEC_W] = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            state_d = APPLY;
          end
        end
      end
      APPLY: begin
        vec_d = stage_q[VEC_W-1:0];
        if (tsum[CNT_W]) begin
          tog_d = '1;
        end else begin
          tog_d = tsum[CNT_W-1:0];
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        odata_d  = res_i;
        ovalid_d = 1'b1;
        state_d  = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          vcnt_d   = vcnt_q + 1'b1;
          idx_d    = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (clr_stats) begin
      tog_d  = '0;
      vcnt_d = '0;
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      stage_q  <= '0;
      vec_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      tog_q    <= '0;
      vcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stage_q  <= stage_d;
      vec_q    <= vec_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      tog_q    <= tog_d;
      vcnt_q   <= vcnt_d;
    end
  end

endmodule
